rfifo_rd_ctrl: RTL and testbench

//  Parametrised read-side pointer/flag controller for the UART async FIFO; generalises
//  the fixed 4-bit read pointer to any depth 2**A. It converts binary to Gray

---
 rtl/rfifo_rd_ctrl.sv | 64 ++++++
 tb/tb_rfifo_rd_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rfifo_rd_ctrl.sv
// Read-side pointer and flag controller for the UART async FIFO, depth 2**A.
// Runs entirely in the read clock domain against an already-synchronised Gray write pointer.
module rfifo_rd_ctrl #(
  parameter int A         = 3,
  parameter int AE_THRESH = 1
) (
  input  logic         rclk,
  input  logic         rrst,
  input  logic         rinc,
  input  logic         clr_underflow,
  input  logic [A:0]   s_g_wptr,
  output logic [A-1:0] raddr,
  output logic [A:0]   g_rptr,
  output logic         rempty,
  output logic         ralmost_empty,
  output logic [A:0]   rlevel,
  output logic         runderflow
);

  localparam logic [A:0] AE_LIMIT = (A+1)'(AE_THRESH);

  logic [A:0] rptr;
  logic [A:0] rptr_nxt;
  logic [A:0] g_nxt;
  logic [A:0] wbin;
  logic [A:0] level_nxt;
  logic       rpop;
  logic       underflow_hit;

  assign rpop          = rinc & ~rempty;
  assign underflow_hit = rinc & rempty;
  assign rptr_nxt      = rptr + {{A{1'b0}}, rpop};
  assign g_nxt         = rptr_nxt ^ (rptr_nxt >> 1);
  assign level_nxt     = wbin - rptr_nxt;
  assign raddr         = rptr[A-1:0];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= A; i++) begin
      wbin[i] = ^(s_g_wptr >> i);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rptr          <= '0;
      g_rptr        <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
    end else begin
      rptr          <= rptr_nxt;
      g_rptr        <= g_nxt;
      rempty        <= (g_nxt == s_g_wptr);
      ralmost_empty <= (level_nxt <= AE_LIMIT);
      rlevel        <= level_nxt;
      // A fresh underflow takes priority over a simultaneous clear.
      runderflow    <= underflow_hit | (runderflow & ~clr_underflow);
    end
  end

endmodule

// File: tb/tb_rfifo_rd_ctrl.sv
// Directed bench for rfifo_rd_ctrl: A=3/AE_THRESH=1 instance plus an A=5/AE_THRESH=0
// instance scoreboarded against a small occupancy model.
module tb_rfifo_rd_ctrl;

  logic       rclk = 1'b0;
  int         n_compared = 0;
  int         n_mismatched = 0;

  // A=3, AE_THRESH=1 instance
  logic       rrst, rinc, clr_underflow;
  logic [3:0] s_g_wptr;
  logic [2:0] raddr;
  logic [3:0] g_rptr;
  logic       rempty, ralmost_empty, runderflow;
  logic [3:0] rlevel;

  // A=5, AE_THRESH=0 instance
  logic       b_rrst, b_rinc, b_clr;
  logic [5:0] b_s_g_wptr;
  logic [4:0] b_raddr;
  logic [5:0] b_g_rptr;
  logic       b_rempty, b_ralmost_empty, b_runderflow;
  logic [5:0] b_rlevel;

  // B-side reference model
  logic [5:0] m_w, m_r, m_lvl;
  logic       m_empty, m_under, m_pop, m_rd;
  logic [3:0] prev_g;

  always #5 rclk = ~rclk;

  rfifo_rd_ctrl #(.A(3), .AE_THRESH(1)) dut_a (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .clr_underflow(clr_underflow),
    .s_g_wptr(s_g_wptr), .raddr(raddr), .g_rptr(g_rptr), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel), .runderflow(runderflow)
  );

  rfifo_rd_ctrl #(.A(5), .AE_THRESH(0)) dut_b (
    .rclk(rclk), .rrst(b_rrst), .rinc(b_rinc), .clr_underflow(b_clr),
    .s_g_wptr(b_s_g_wptr), .raddr(b_raddr), .g_rptr(b_g_rptr), .rempty(b_rempty),
    .ralmost_empty(b_ralmost_empty), .rlevel(b_rlevel), .runderflow(b_runderflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Drive the A=3 instance for one cycle and let the edge land.
  task automatic applyStimulus(input logic rst, input logic inc, input logic clr,
                               input logic [3:0] gw);
    rrst = rst; rinc = inc; clr_underflow = clr; s_g_wptr = gw;
    tick();
  endtask

  task automatic checkA(input string tag, input logic [2:0] e_raddr, input logic [3:0] e_g,
                        input logic e_empty, input logic e_ae, input logic [3:0] e_lvl,
                        input logic e_under);
    checkOutput({tag, ".raddr"},  32'(raddr),         32'(e_raddr));
    checkOutput({tag, ".g_rptr"}, 32'(g_rptr),        32'(e_g));
    checkOutput({tag, ".rempty"}, 32'(rempty),        32'(e_empty));
    checkOutput({tag, ".ae"},     32'(ralmost_empty), 32'(e_ae));
    checkOutput({tag, ".rlevel"}, 32'(rlevel),        32'(e_lvl));
    checkOutput({tag, ".uflow"},  32'(runderflow),    32'(e_under));
  endtask

  function automatic logic [5:0] gray6(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkB(input string tag);
    checkOutput({tag, ".rlevel"}, 32'(b_rlevel),        32'(m_lvl));
    checkOutput({tag, ".rempty"}, 32'(b_rempty),        32'(m_empty));
    checkOutput({tag, ".ae"},     32'(b_ralmost_empty), 32'(m_empty));
    checkOutput({tag, ".raddr"},  32'(b_raddr),         32'(m_r[4:0]));
    checkOutput({tag, ".g_rptr"}, 32'(b_g_rptr),        32'(gray6(m_r)));
    checkOutput({tag, ".uflow"},  32'(b_runderflow),    32'(m_under));
  endtask

  task automatic runModelB(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      m_rd  = 1'($urandom_range(0, 1));
      m_pop = m_rd & ~m_empty;
      if (m_rd & m_empty) m_under = 1'b1;
      if (($urandom_range(0, 2) != 0) && ((m_w - m_r) < 6'd32)) m_w = m_w + 6'd1;
      b_rinc = m_rd; b_s_g_wptr = gray6(m_w);
      tick();
      m_r     = m_r + {5'd0, m_pop};
      m_lvl   = m_w - m_r;
      m_empty = (m_lvl == 6'd0);
      checkB("b_rand");
    end
  endtask

  initial begin
    b_rrst = 1'b1; b_rinc = 1'b0; b_clr = 1'b0; b_s_g_wptr = '0;

    // Reset for two cycles
    applyStimulus(1, 0, 0, 4'd0);
    applyStimulus(1, 0, 0, 4'd0);
    checkA("reset", 3'd0, 4'd0, 1, 1, 4'd0, 0);

    // Write pointer steps Gray 1,3,2 then three pops
    applyStimulus(0, 0, 0, 4'b0001); checkA("w1", 3'd0, 4'd0, 0, 1, 4'd1, 0);
    applyStimulus(0, 0, 0, 4'b0011); checkA("w2", 3'd0, 4'd0, 0, 0, 4'd2, 0);
    applyStimulus(0, 0, 0, 4'b0010); checkA("w3", 3'd0, 4'd0, 0, 0, 4'd3, 0);
    applyStimulus(0, 1, 0, 4'b0010); checkA("p1", 3'd1, 4'b0001, 0, 0, 4'd2, 0);
    applyStimulus(0, 1, 0, 4'b0010); checkA("p2", 3'd2, 4'b0011, 0, 1, 4'd1, 0);
    applyStimulus(0, 1, 0, 4'b0010); checkA("p3", 3'd3, 4'b0010, 1, 1, 4'd0, 0);

    // Underflow: sticky, set beats clear, clear alone drops it
    applyStimulus(0, 1, 0, 4'b0010); checkA("uf_set",  3'd3, 4'b0010, 1, 1, 4'd0, 1);
    applyStimulus(0, 1, 1, 4'b0010); checkA("uf_both", 3'd3, 4'b0010, 1, 1, 4'd0, 1);
    applyStimulus(0, 0, 0, 4'b0010); checkA("uf_hold", 3'd3, 4'b0010, 1, 1, 4'd0, 1);
    applyStimulus(0, 0, 1, 4'b0010); checkA("uf_clr",  3'd3, 4'b0010, 1, 1, 4'd0, 0);

    // Full, then 16 simultaneous write/read steps through the pointer wrap
    applyStimulus(1, 0, 0, 4'd0);
    applyStimulus(0, 0, 0, 4'b1100); checkA("full", 3'd0, 4'd0, 0, 0, 4'd8, 0);
    prev_g = g_rptr;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] wb, rb;
      wb = 4'(9 + k);
      rb = 4'(k + 1);
      applyStimulus(0, 1, 0, wb ^ (wb >> 1));
      checkOutput("wrap.g_rptr", 32'(g_rptr), 32'(rb ^ (rb >> 1)));
      checkOutput("wrap.raddr",  32'(raddr),  32'(rb[2:0]));
      checkOutput("wrap.rlevel", 32'(rlevel), 32'd8);
      checkOutput("wrap.onebit", 32'($countones(g_rptr ^ prev_g)), 32'd1);
      if (k == 14) checkOutput("wrap.g15", 32'(g_rptr), 32'b1000);
      if (k == 15) checkOutput("wrap.g0",  32'(g_rptr), 32'b0000);
      prev_g = g_rptr;
    end
    rinc = 1'b0;

    // Pop and write in the same cycle at level 1
    applyStimulus(1, 0, 0, 4'd0);
    applyStimulus(0, 0, 0, 4'b0001); checkA("lv1", 3'd0, 4'd0, 0, 1, 4'd1, 0);
    applyStimulus(0, 1, 0, 4'b0011); checkA("popwr", 3'd1, 4'b0001, 0, 1, 4'd1, 0);

    // Mid-stream reset at level 5 with a pop pending
    applyStimulus(0, 0, 0, 4'b0101); checkA("lv5", 3'd1, 4'b0001, 0, 0, 4'd5, 0);
    applyStimulus(1, 1, 0, 4'b0101); checkA("midrst", 3'd0, 4'd0, 1, 1, 4'd0, 0);
    applyStimulus(0, 0, 0, 4'd0);

    // A=5, AE_THRESH=0 instance against the model
    tick();
    m_w = '0; m_r = '0; m_lvl = '0; m_empty = 1'b1; m_under = 1'b0;
    checkB("b_reset");
    b_rrst = 1'b0;
    runModelB(120);
    b_rrst = 1'b1; b_rinc = 1'b1;
    tick();
    m_w = '0; m_r = '0; m_lvl = '0; m_empty = 1'b1; m_under = 1'b0;
    b_s_g_wptr = '0;
    checkB("b_midrst");
    b_rrst = 1'b0; b_rinc = 1'b0;
    runModelB(120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
